// File: rtl/riscuin_multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the RISCuin core: owns the PC, steps
// FETCH/DECODE/EXEC/MEM/WB, handshakes the data bus with a timeout and counts retirements.
module riscuin_multicycle_sequencer #(
    parameter int INSTR_ADDR_WIDTH = 8,
    parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [INSTR_ADDR_WIDTH-1:0] LAST_PC  = '1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rb_ready,
    input  logic [31:0]                 instr_in,
    input  logic                        dec_reg_w,
    input  logic                        dec_mem_r,
    input  logic                        dec_mem_w,
    input  logic                        dec_halt,
    input  logic                        dec_jump,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc_branch,
    input  logic                        mem_ready,
    output logic [INSTR_ADDR_WIDTH-1:0] pc,
    output logic [INSTR_ADDR_WIDTH-1:0] pc_plus,
    output logic [31:0]                 instr,
    output logic                        reg_w,
    output logic                        mem_r,
    output logic                        mem_w,
    output logic                        pc_end,
    output logic                        bus_err,
    output logic [31:0]                 instret,
    output logic [2:0]                  state
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t                      state_q, state_d;
    logic [INSTR_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]                 instr_q, instr_d;
    logic                        reg_w_q, reg_w_d;
    logic                        pc_end_q, pc_end_d;
    logic                        bus_err_q, bus_err_d;
    logic [31:0]                 instret_q, instret_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            reg_w_q   <= 1'b0;
            pc_end_q  <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            reg_w_q   <= reg_w_d;
            pc_end_q  <= pc_end_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        reg_w_d   = 1'b0;
        bus_err_d = bus_err_q;
        instret_d = instret_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rb_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                instr_d = instr_in;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = dec_halt ? S_HALT : S_EXEC;
            end
            // reg_w is registered, so it is loaded on the edge that enters WB
            S_EXEC: begin
                if (dec_mem_r || dec_mem_w) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                    reg_w_d = dec_reg_w;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WB;
                    reg_w_d = dec_reg_w;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                instret_d = instret_q + 32'd1;
                if (dec_jump) begin
                    pc_d    = pc_branch;
                    state_d = S_FETCH;
                end else if (pc_q == LAST_PC) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_plus;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pc_end_d = pc_end_q || (state_d == S_HALT);
    end

    assign pc_plus = pc_q + INSTR_ADDR_WIDTH'(1);
    assign mem_r   = (state_q == S_MEM) && dec_mem_r;
    assign mem_w   = (state_q == S_MEM) && dec_mem_w && !dec_mem_r;
    assign pc      = pc_q;
    assign instr   = instr_q;
    assign reg_w   = reg_w_q;
    assign pc_end  = pc_end_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_riscuin_multicycle_sequencer.sv
// Bench for riscuin_multicycle_sequencer: table vectors, hand-written corner sequences
// and random instruction streams checked against an instruction-level reference model.
module tb_riscuin_multicycle_sequencer;
    localparam int IAW = 8;
    localparam int TMO = 15;
    localparam int NEVER = 99;

    logic clk = 1'b0;
    logic rst, rb_ready, dec_reg_w, dec_mem_r, dec_mem_w, dec_halt, dec_jump, mem_ready;
    logic [31:0] instr_in;
    logic [IAW-1:0] pc_branch, pc, pc_plus;
    logic [31:0] instr, instret;
    logic reg_w, mem_r, mem_w, pc_end, bus_err;
    logic [2:0] state;

    riscuin_multicycle_sequencer #(.INSTR_ADDR_WIDTH(IAW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rb_ready(rb_ready), .instr_in(instr_in),
        .dec_reg_w(dec_reg_w), .dec_mem_r(dec_mem_r), .dec_mem_w(dec_mem_w),
        .dec_halt(dec_halt), .dec_jump(dec_jump), .pc_branch(pc_branch),
        .mem_ready(mem_ready), .pc(pc), .pc_plus(pc_plus), .instr(instr),
        .reg_w(reg_w), .mem_r(mem_r), .mem_w(mem_w), .pc_end(pc_end),
        .bus_err(bus_err), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rw, mr, mw, hlt, jmp;
        logic [7:0] tgt;
        int wt;       // wait cycles before mem_ready; >= TMO means never
        int exp_cyc;  // hand-computed instruction length, -1 when not given
    } vec_t;

    typedef struct {
        int cyc, rw, mr, mw;
        logic halt, berr;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cur_idx = 0;

    logic [7:0]  m_pc;
    logic [31:0] m_instret;
    logic        m_end, m_berr;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (instr #%0d) actual=%0h required=%0h", name, cur_idx, act, req);
        end
    endtask

    // Instruction-level reference: length in cycles, strobe counts, and architectural effect.
    task automatic model(input vec_t v, output exp_t e);
        int n;
        bit wb;
        e.cyc = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.halt = 1'b0; e.berr = 1'b0;
        wb = 1'b1;
        if (v.hlt) begin
            e.cyc = 2;
            e.halt = 1'b1;
            wb = 1'b0;
        end else if (v.mr || v.mw) begin
            n = (v.wt >= TMO) ? TMO : v.wt + 1;
            if (v.mr) e.mr = n; else e.mw = n;
            if (v.wt >= TMO) begin
                e.cyc = 3 + TMO;
                e.halt = 1'b1;
                e.berr = 1'b1;
                wb = 1'b0;
            end else begin
                e.cyc = 4 + n;
            end
        end else begin
            e.cyc = 4;
        end
        if (wb) begin
            e.rw = v.rw ? 1 : 0;
            m_instret = m_instret + 32'd1;
            if (v.jmp) m_pc = v.tgt;
            else if (m_pc == 8'hFF) e.halt = 1'b1;
            else m_pc = m_pc + 8'd1;
        end
        m_end  = m_end | e.halt;
        m_berr = m_berr | e.berr;
    endtask

    task automatic clear_dec();
        dec_reg_w = 0; dec_mem_r = 0; dec_mem_w = 0; dec_halt = 0; dec_jump = 0;
        pc_branch = '0; mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rb_ready = 1'b0;
        clear_dec();
        instr_in = $urandom;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instret", instret, 32'd0);
        check("rst_flags", {29'd0, pc_end, bus_err, reg_w}, 32'd0);
        rst = 1'b0;
        m_pc = 8'd0; m_instret = 32'd0; m_end = 1'b0; m_berr = 1'b0;
    endtask

    task automatic start();
        rb_ready = 1'b1;
        @(negedge clk);
        check("start_fetch", 32'(state), 32'd1);
    endtask

    // Called mid-cycle with the DUT in FETCH; returns mid-cycle in the next FETCH or in HALT.
    task automatic run_instr(input vec_t v);
        exp_t e;
        logic [31:0] iw;
        int cyc, rw, mr, mw;
        bit done;
        model(v, e);
        iw = $urandom;
        instr_in = iw;
        dec_reg_w = v.rw; dec_mem_r = v.mr; dec_mem_w = v.mw;
        dec_halt = v.hlt; dec_jump = v.jmp; pc_branch = v.tgt;
        cyc = 0; rw = 0; mr = 0; mw = 0; done = 0;
        while (!done) begin
            if (reg_w) rw++;
            if (mem_r) mr++;
            if (mem_w) mw++;
            if ((v.mr || v.mw) && cyc >= 3) mem_ready = (cyc == 3 + v.wt);
            else mem_ready = 1'($urandom_range(0, 1));
            rb_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("instr_latch", instr, iw);
            if (state == 3'd1 || state == 3'd6) done = 1;
            else if (cyc >= 40) begin
                check("cycle_bound", 32'(cyc), 32'(e.cyc));
                done = 1;
            end
        end
        mem_ready = 1'b0;
        check("cycles", 32'(cyc), 32'(e.cyc));
        if (v.exp_cyc >= 0) check("table_cycles", 32'(cyc), 32'(v.exp_cyc));
        check("reg_w_pulses", 32'(rw), 32'(e.rw));
        check("mem_r_cycles", 32'(mr), 32'(e.mr));
        check("mem_w_cycles", 32'(mw), 32'(e.mw));
        check("pc", 32'(pc), 32'(m_pc));
        check("instret", instret, m_instret);
        check("end_state", 32'(state), e.halt ? 32'd6 : 32'd1);
        check("pc_end", 32'(pc_end), 32'(m_end));
        check("bus_err", 32'(bus_err), 32'(m_berr));
        check("idle_bus", {30'd0, mem_r, mem_w}, 32'd0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        rb_ready = 1'b0;
        instr_in = '0;
        clear_dec();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_wait_state", 32'(state), 32'd0);
            check("idle_wait_pc", 32'(pc), 32'd0);
        end
        start();

        //            rw mr mw hl jp tgt    wt     cyc
        tbl[0]  = '{1, 0, 0, 0, 0, 8'h00, 0,     4};
        tbl[1]  = '{1, 0, 0, 0, 0, 8'h00, 0,     4};
        tbl[2]  = '{1, 0, 0, 0, 0, 8'h00, 0,     4};
        tbl[3]  = '{0, 0, 0, 0, 0, 8'h00, 0,     4};
        tbl[4]  = '{1, 0, 0, 0, 1, 8'h10, 0,     4};
        tbl[5]  = '{1, 1, 0, 0, 0, 8'h00, 3,     8};
        tbl[6]  = '{0, 0, 1, 0, 0, 8'h00, 0,     5};
        tbl[7]  = '{1, 1, 1, 0, 0, 8'h00, 1,     6};
        tbl[8]  = '{1, 1, 0, 0, 0, 8'h00, 14,    19};
        tbl[9]  = '{0, 0, 0, 0, 1, 8'hFE, 0,     4};
        tbl[10] = '{1, 0, 0, 0, 0, 8'h00, 0,     4};
        tbl[11] = '{1, 0, 0, 0, 0, 8'h00, 0,     4};
        tbl[12] = '{0, 0, 0, 0, 1, 8'hFF, 0,     4};
        tbl[13] = '{1, 0, 0, 0, 1, 8'h05, 0,     4};
        tbl[14] = '{1, 0, 0, 1, 0, 8'h00, 0,     2};
        tbl[15] = '{0, 0, 1, 0, 0, 8'h00, NEVER, 18};

        for (int i = 0; i < 16; i++) begin
            cur_idx = i;
            run_instr(tbl[i]);
            if (m_end) begin
                do_reset();
                start();
            end
        end

        // Reset while a load is waiting on the bus.
        cur_idx = 100;
        dec_mem_r = 1'b1; dec_reg_w = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("midmem_state", 32'(state), 32'd4);
        check("midmem_mem_r", 32'(mem_r), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_midmem_state", 32'(state), 32'd0);
        check("rst_midmem_mem_r", 32'(mem_r), 32'd0);
        do_reset();
        start();

        for (int i = 0; i < 200; i++) begin
            int r;
            cur_idx = 200 + i;
            r = $urandom_range(0, 99);
            v.rw  = 1'($urandom_range(0, 1));
            v.mr  = (r < 25);
            v.mw  = (r >= 25 && r < 45);
            v.hlt = (r == 99);
            v.jmp = ($urandom_range(0, 4) == 0);
            v.tgt = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) v.wt = NEVER;
            else if ($urandom_range(0, 9) == 0) v.wt = $urandom_range(5, 14);
            else v.wt = $urandom_range(0, 4);
            v.exp_cyc = -1;
            run_instr(v);
            if (m_end) begin
                do_reset();
                start();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
